// File: rtl/i2c_codec_responder_if.sv
// Bus bundle for the codec-side I2C responder: pins from the I2C bus plus the
// register-write observation outputs.
interface i2c_codec_responder_if #(
   parameter int NREG = 11
);
   logic              i_scl;
   logic              i_sda;
   logic              o_sda_oe;
   logic              o_wr_valid;
   logic [6:0]        o_wr_addr;
   logic [8:0]        o_wr_data;
   logic [NREG*9-1:0] o_regs;
   logic [7:0]        o_nwrites;
   logic [2:0]        o_state;

   modport slave (
      input  i_scl, i_sda,
      output o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_regs, o_nwrites, o_state
   );

   modport master (
      output i_scl, i_sda,
      input  o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_regs, o_nwrites, o_state
   );
endinterface

// File: rtl/i2c_codec_responder.sv
// WM8731-style write-only I2C control port: oversampled SCL/SDA, open-drain ACK,
// 2-byte 9-bit register writes into a small register file.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         NREG     = 11,
   parameter int         SYNC     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   i2c_codec_responder_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ACK       = 3'd2,
      S_BYTE1     = 3'd3,
      S_BYTE2     = 3'd4,
      S_WAIT_STOP = 3'd5
   } state_t;

   localparam logic [6:0] REG_CLEAR = 7'd15;

   state_t            state_q, state_d;
   state_t            ack_next_q, ack_next_d;
   logic              ack_drive_q, ack_drive_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        shift_q, shift_d;
   logic [6:0]        reg_q, reg_d;
   logic              d8_q, d8_d;
   logic              wr_valid_q, wr_valid_d;
   logic [6:0]        wr_addr_q, wr_addr_d;
   logic [8:0]        wr_data_q, wr_data_d;
   logic [7:0]        nwrites_q, nwrites_d;
   logic [8:0]        regs_q [NREG];
   logic [8:0]        regs_d [NREG];
   logic [SYNC-1:0]   scl_sync_q, scl_sync_d;
   logic [SYNC-1:0]   sda_sync_q, sda_sync_d;
   logic              scl_hist_q, sda_hist_q;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, start_det, stop_det;
   logic last_bit;
   logic [7:0] rx_byte;

   // Edges are judged between the synchronized sample and one older sample.
   assign scl_sync_d = {scl_sync_q[SYNC-2:0], bus.i_scl};
   assign sda_sync_d = {sda_sync_q[SYNC-2:0], bus.i_sda};
   assign scl_s      = scl_sync_q[SYNC-1];
   assign sda_s      = sda_sync_q[SYNC-1];
   assign scl_rise   = scl_s & ~scl_hist_q;
   assign scl_fall   = ~scl_s & scl_hist_q;
   assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
   assign last_bit   = scl_rise & (bit_cnt_q == 3'd7);
   assign rx_byte    = {shift_q, sda_s};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         ack_next_q  <= S_IDLE;
         ack_drive_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 7'd0;
         reg_q       <= 7'd0;
         d8_q        <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= 7'd0;
         wr_data_q   <= 9'd0;
         nwrites_q   <= 8'd0;
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_hist_q  <= 1'b1;
         sda_hist_q  <= 1'b1;
         for (int k = 0; k < NREG; k++) regs_q[k] <= 9'd0;
      end else begin
         state_q     <= state_d;
         ack_next_q  <= ack_next_d;
         ack_drive_q <= ack_drive_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         reg_q       <= reg_d;
         d8_q        <= d8_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         nwrites_q   <= nwrites_d;
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_hist_q  <= scl_s;
         sda_hist_q  <= sda_s;
         for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
      end
   end

   always_comb begin
      state_d    = state_q;
      ack_next_d = ack_next_q;
      if (start_det) begin
         state_d = S_ADDR;
      end else if (stop_det) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (last_bit) begin
                  if (rx_byte == {DEV_ADDR, 1'b0}) begin
                     state_d    = S_ACK;
                     ack_next_d = S_BYTE1;
                  end else begin
                     state_d = S_WAIT_STOP;
                  end
               end
            end
            S_BYTE1: begin
               if (last_bit) begin
                  state_d    = S_ACK;
                  ack_next_d = S_BYTE2;
               end
            end
            S_BYTE2: begin
               if (last_bit) begin
                  state_d    = S_ACK;
                  ack_next_d = S_WAIT_STOP;
               end
            end
            S_ACK: begin
               if (scl_fall && ack_drive_q) state_d = ack_next_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ack_drive_d = ack_drive_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      reg_d       = reg_q;
      d8_d        = d8_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      nwrites_d   = nwrites_q;
      for (int k = 0; k < NREG; k++) regs_d[k] = regs_q[k];

      if (start_det || stop_det) begin
         bit_cnt_d   = 3'd0;
         ack_drive_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_BYTE1, S_BYTE2, S_WAIT_STOP: begin
               if (scl_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (last_bit && state_q == S_BYTE1) begin
                  reg_d = rx_byte[7:1];
                  d8_d  = rx_byte[0];
               end
               if (last_bit && state_q == S_BYTE2) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = reg_q;
                  wr_data_d  = {d8_q, rx_byte};
                  if (nwrites_q != 8'hFF) nwrites_d = nwrites_q + 8'd1;
                  if (reg_q == REG_CLEAR) begin
                     for (int k = 0; k < NREG; k++) regs_d[k] = 9'd0;
                  end else begin
                     for (int k = 0; k < NREG; k++)
                        if (reg_q == 7'(k)) regs_d[k] = {d8_q, rx_byte};
                  end
               end
            end
            S_ACK: begin
               // First falling edge starts the low pulse, the second ends it.
               if (scl_fall) ack_drive_d = ~ack_drive_q;
            end
            default: ;
         endcase
      end
   end

   // Combinational gate so a START/STOP inside the ACK slot lets go of SDA at once.
   assign bus.o_sda_oe   = (state_q == S_ACK) & ack_drive_q & ~start_det & ~stop_det;
   assign bus.o_wr_valid = wr_valid_q;
   assign bus.o_wr_addr  = wr_addr_q;
   assign bus.o_wr_data  = wr_data_q;
   assign bus.o_nwrites  = nwrites_q;
   assign bus.o_state    = state_q;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_regs
         assign bus.o_regs[9*gi +: 9] = regs_q[gi];
      end
   endgenerate
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master, transaction-level
// model of the codec register file, directed cases followed by random writes.
module tb_i2c_codec_responder;
   localparam int NREG = 11;
   localparam int Q    = 5;

   logic clk = 1'b0;
   logic rst;
   logic scl_m, sda_m;
   always #5 clk = ~clk;

   i2c_codec_responder_if #(.NREG(NREG)) bus ();
   assign bus.i_scl = scl_m;
   assign bus.i_sda = sda_m & ~bus.o_sda_oe;

   i2c_codec_responder #(.DEV_ADDR(7'h1A), .NREG(NREG), .SYNC(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int valid_cycles = 0;
   int oe_cycles    = 0;

   always @(negedge clk) begin
      if (bus.o_wr_valid) valid_cycles++;
      if (bus.o_sda_oe)   oe_cycles++;
   end

   logic [8:0] mregs [NREG];
   int         mstrobes = 0;
   int         mnw      = 0;
   logic [6:0] maddr    = 7'd0;
   logic [8:0] mdata    = 9'd0;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREG*9-1:0] mpack();
      logic [NREG*9-1:0] v;
      for (int k = 0; k < NREG; k++) v[9*k +: 9] = mregs[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) mregs[k] = 9'd0;
      mnw   = 0;
      maddr = 7'd0;
      mdata = 9'd0;
   endtask

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(2 * Q);
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wq(Q);
         scl_m = 1'b1; wq(2 * Q);
         scl_m = 1'b0; wq(Q);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      send_bits(b);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      @(negedge clk);
      acked = ~bus.i_sda;
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   // One transaction: START, n bytes, optional STOP; expectations from the codec rules.
   task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int n,
                          input bit do_stop);
      logic [7:0] bytes [4];
      logic       acked;
      bit         addr_ok;
      int         oe0;
      bytes[0] = a; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      addr_ok  = (a == 8'h34);
      oe0      = oe_cycles;
      i2c_start();
      for (int i = 0; i < n; i++) begin
         send_byte(bytes[i], acked);
         check($sformatf("%s_ack%0d", tag, i), acked, addr_ok && i <= 2);
      end
      if (addr_ok && n >= 3) begin
         mstrobes++;
         maddr = b1[7:1];
         mdata = {b1[0], b2};
         if (maddr == 7'd15) begin
            for (int k = 0; k < NREG; k++) mregs[k] = 9'd0;
         end else if (int'(maddr) < NREG) begin
            mregs[maddr] = mdata;
         end
         if (mnw < 255) mnw++;
      end
      if (do_stop) begin
         i2c_stop();
         @(negedge clk);
         check({tag, "_strobes"}, valid_cycles, mstrobes);
         check({tag, "_regs"},    bus.o_regs, mpack());
         check({tag, "_nwrites"}, bus.o_nwrites, mnw);
         check({tag, "_addr"},    bus.o_wr_addr, maddr);
         check({tag, "_data"},    bus.o_wr_data, mdata);
         check({tag, "_state"},   bus.o_state, 3'd0);
         if (!addr_ok) check({tag, "_no_oe"}, oe_cycles - oe0, 0);
      end
      $display("txn %s: %02h %02h %02h %02h n=%0d stop=%0d strobes=%0d nwrites=%0d",
               tag, a, b1, b2, b3, n, do_stop, mstrobes, mnw);
   endtask

   task automatic pulse_reset();
      rst = 1'b1; wq(2);
      rst = 1'b0; wq(2);
      model_reset();
   endtask

   initial begin
      logic acked;
      logic [7:0] a, b1, b2;
      int nb;
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      model_reset();
      wq(3);
      @(negedge clk);
      check("rst_oe",      bus.o_sda_oe, 1'b0);
      check("rst_valid",   bus.o_wr_valid, 1'b0);
      check("rst_addr",    bus.o_wr_addr, 7'd0);
      check("rst_data",    bus.o_wr_data, 9'd0);
      check("rst_regs",    bus.o_regs, '0);
      check("rst_nwrites", bus.o_nwrites, 8'd0);
      check("rst_state",   bus.o_state, 3'd0);
      rst = 1'b0;
      wq(4);

      run_txn("basic", 8'h34, 8'h08, 8'h15, 8'h00, 3, 1'b1);
      check("basic_reg4", bus.o_regs[9*4 +: 9], 9'h015);
      run_txn("badaddr", 8'h36, 8'h08, 8'h15, 8'h00, 3, 1'b1);
      run_txn("read",    8'h35, 8'h0A, 8'h55, 8'h00, 3, 1'b1);

      run_txn("pre6",  8'h34, 8'h0D, 8'hAB, 8'h00, 3, 1'b1);
      run_txn("part",  8'h34, 8'h0D, 8'h00, 8'h00, 2, 1'b0);
      run_txn("rstart", 8'h34, 8'h0C, 8'h00, 8'h00, 3, 1'b1);
      check("rstart_reg6", bus.o_regs[9*6 +: 9], 9'h000);

      pulse_reset();
      run_txn("reg2",  8'h34, 8'h05, 8'h7F, 8'h00, 3, 1'b1);
      check("reg2_val", bus.o_regs[9*2 +: 9], 9'h17F);
      run_txn("clear", 8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1);
      check("clear_nw", bus.o_nwrites, 8'd2);

      // Reset while the responder holds SDA low in the byte-1 ACK slot.
      i2c_start();
      send_byte(8'h34, acked);
      check("mid_ack0", acked, 1'b1);
      send_bits(8'h08);
      @(negedge clk);
      check("mid_oe_on", bus.o_sda_oe, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_oe_off", bus.o_sda_oe, 1'b0);
      check("mid_state",  bus.o_state, 3'd0);
      rst = 1'b0;
      model_reset();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(4 * Q);
      run_txn("after_rst", 8'h34, 8'h12, 8'h5A, 8'h00, 3, 1'b1);

      for (int t = 0; t < 24; t++) begin
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
         nb = $urandom_range(1, 4);
         if ($urandom_range(0, 3) == 0) b1 = 8'($urandom);
         else b1 = {3'b000, 4'($urandom), 1'($urandom)};
         b2 = 8'($urandom);
         run_txn($sformatf("rnd%0d", t), a, b1, b2, 8'($urandom), nb, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
